// File: rtl/match_req_arbiter_pkg.sv
// Shared widths and the request-table entry layout for the match request arbiter.
package match_req_arbiter_pkg;

  localparam int ADDR_WIDTH      = 32;
  localparam int MATCH_LEN_WIDTH = 16;
  localparam int MATCH_TAG_WIDTH = 8;

  // Wide enough for the largest supported requester count (8).
  localparam int OWNER_WIDTH = 3;

  // Payload of one in-flight table entry; the valid bit is kept separately as control state.
  typedef struct packed {
    logic [OWNER_WIDTH-1:0]     owner;
    logic [MATCH_TAG_WIDTH-1:0] tag;
  } entry_t;

endpackage

// File: rtl/match_req_arbiter_rr_arbiter.sv
// Round-robin selector: the search starts one past the last granted requester.
module rr_arbiter
  import match_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] last_q;
  logic [PTR_W-1:0] last_d;
  logic [PTR_W-1:0] gnt_idx;
  logic             found;

  // First requesting index after the pointer wins; at most one grant bit set.
  always_comb begin
    gnt_o   = '0;
    gnt_idx = last_q;
    found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_i[PTR_W'((int'(last_q) + k) % NUM_REQ)]) begin
        found   = 1'b1;
        gnt_idx = PTR_W'((int'(last_q) + k) % NUM_REQ);
        gnt_o[PTR_W'((int'(last_q) + k) % NUM_REQ)] = 1'b1;
      end
    end
    last_d = advance_i ? gnt_idx : last_q;
  end

  // Pointer starts at the top requester so requester 0 is first after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= PTR_W'(NUM_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/match_req_arbiter.sv
// Shares one match PE among NUM_REQ requesters: round-robin grant, tag
// translation through an in-flight table, and tag-routed responses.
module match_req_arbiter
  import match_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int OUTSTANDING_DEPTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   up_req_valid_i,
  output logic [NUM_REQ-1:0]                   up_req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]        up_req_head_addr_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]        up_req_history_addr_i,
  input  logic [NUM_REQ*MATCH_TAG_WIDTH-1:0]   up_req_tag_i,
  output logic                                 dn_req_valid_o,
  input  logic                                 dn_req_ready_i,
  output logic [ADDR_WIDTH-1:0]                dn_req_head_addr_o,
  output logic [ADDR_WIDTH-1:0]                dn_req_history_addr_o,
  output logic [MATCH_TAG_WIDTH-1:0]           dn_req_tag_o,
  input  logic                                 dn_resp_valid_i,
  output logic                                 dn_resp_ready_o,
  input  logic [MATCH_LEN_WIDTH-1:0]           dn_resp_len_i,
  input  logic [MATCH_TAG_WIDTH-1:0]           dn_resp_tag_i,
  output logic [NUM_REQ-1:0]                   up_resp_valid_o,
  input  logic [NUM_REQ-1:0]                   up_resp_ready_i,
  output logic [NUM_REQ*MATCH_LEN_WIDTH-1:0]   up_resp_len_o,
  output logic [NUM_REQ*MATCH_TAG_WIDTH-1:0]   up_resp_tag_o,
  output logic [$clog2(OUTSTANDING_DEPTH):0]   outstanding_cnt_o,
  output logic                                 stray_resp_err_o
);

  localparam int IDX_W = $clog2(OUTSTANDING_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // Lowest-index free entry; MSB of the result flags that one exists.
  function automatic logic [IDX_W:0] find_free(input logic [OUTSTANDING_DEPTH-1:0] busy);
    logic [IDX_W:0] res;
    res = '0;
    for (int e = OUTSTANDING_DEPTH - 1; e >= 0; e--) begin
      if (!busy[e]) res = {1'b1, IDX_W'(e)};
    end
    return res;
  endfunction

  // Control state
  logic [OUTSTANDING_DEPTH-1:0] valid_q, valid_d;
  logic                         dn_req_valid_q, dn_req_valid_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         stray_q, stray_d;

  // Data state
  entry_t                       ent_q [OUTSTANDING_DEPTH];
  logic [ADDR_WIDTH-1:0]        dn_head_q;
  logic [ADDR_WIDTH-1:0]        dn_hist_q;
  logic [MATCH_TAG_WIDTH-1:0]   dn_tag_q;

  // Request side
  logic [IDX_W:0]               free_res;
  logic                         free_found;
  logic [IDX_W-1:0]             free_idx;
  logic                         can_grant;
  logic [NUM_REQ-1:0]           gnt;
  logic                         grant_any;
  logic [OWNER_WIDTH-1:0]       gnt_owner;
  logic [ADDR_WIDTH-1:0]        gnt_head;
  logic [ADDR_WIDTH-1:0]        gnt_hist;
  logic [MATCH_TAG_WIDTH-1:0]   gnt_tag;

  // Response side
  logic                         resp_in_range;
  logic [IDX_W-1:0]             resp_idx;
  logic                         resp_hit;
  entry_t                       resp_entry;
  logic                         resp_fire;

  // Allocation looks only at the free map from the start of the cycle.
  assign free_res   = find_free(valid_q);
  assign free_found = free_res[IDX_W];
  assign free_idx   = free_res[IDX_W-1:0];

  // A grant needs a free entry and an output register that is empty or draining.
  assign can_grant = rst_n && free_found && (!dn_req_valid_q || dn_req_ready_i);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (up_req_valid_i & {NUM_REQ{can_grant}}),
    .advance_i (grant_any),
    .gnt_o     (gnt)
  );

  assign grant_any      = |gnt;
  assign up_req_ready_o = gnt;

  // Select the granted requester's fields.
  always_comb begin
    gnt_owner = '0;
    gnt_head  = '0;
    gnt_hist  = '0;
    gnt_tag   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_owner = OWNER_WIDTH'(i);
        gnt_head  = up_req_head_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        gnt_hist  = up_req_history_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        gnt_tag   = up_req_tag_i[i*MATCH_TAG_WIDTH +: MATCH_TAG_WIDTH];
      end
    end
  end

  // Tags beyond the table depth or pointing at a free entry are strays.
  assign resp_in_range = ({1'b0, dn_resp_tag_i} < (MATCH_TAG_WIDTH + 1)'(OUTSTANDING_DEPTH));
  assign resp_idx      = dn_resp_tag_i[IDX_W-1:0];
  assign resp_hit      = resp_in_range && valid_q[resp_idx];
  assign resp_entry    = ent_q[resp_idx];

  // Zero-latency routing to the owner; strays are always accepted and dropped.
  always_comb begin
    up_resp_valid_o = '0;
    dn_resp_ready_o = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (resp_hit && (resp_entry.owner == OWNER_WIDTH'(i))) begin
        up_resp_valid_o[i] = dn_resp_valid_i;
        dn_resp_ready_o    = up_resp_ready_i[i];
      end
    end
  end

  assign up_resp_len_o = {NUM_REQ{dn_resp_len_i}};
  assign up_resp_tag_o = {NUM_REQ{resp_entry.tag}};
  assign resp_fire     = dn_resp_valid_i && dn_resp_ready_o && resp_hit;

  // Next control state: free and allocate never touch the same entry.
  always_comb begin
    valid_d = valid_q;
    if (resp_fire) valid_d[resp_idx] = 1'b0;
    if (grant_any) valid_d[free_idx] = 1'b1;
    cnt_d          = cnt_q + CNT_W'(grant_any) - CNT_W'(resp_fire);
    dn_req_valid_d = grant_any ? 1'b1 : (dn_req_ready_i ? 1'b0 : dn_req_valid_q);
    stray_d        = stray_q | (dn_resp_valid_i && !resp_hit);
  end

  // Control registers; reset drops every in-flight entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q        <= '0;
      dn_req_valid_q <= 1'b0;
      cnt_q          <= '0;
      stray_q        <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      dn_req_valid_q <= dn_req_valid_d;
      cnt_q          <= cnt_d;
      stray_q        <= stray_d;
    end
  end

  // Table payload and output register load on grant and hold otherwise.
  always_ff @(posedge clk) begin
    if (grant_any) begin
      ent_q[free_idx] <= '{owner: gnt_owner, tag: gnt_tag};
      dn_head_q       <= gnt_head;
      dn_hist_q       <= gnt_hist;
      dn_tag_q        <= MATCH_TAG_WIDTH'(free_idx);
    end
  end

  assign dn_req_valid_o        = dn_req_valid_q;
  assign dn_req_head_addr_o    = dn_head_q;
  assign dn_req_history_addr_o = dn_hist_q;
  assign dn_req_tag_o          = dn_tag_q;
  assign outstanding_cnt_o     = cnt_q;
  assign stray_resp_err_o      = stray_q;

endmodule

// File: tb/tb_match_req_arbiter.sv
// Scenario bench for match_req_arbiter with a scoreboard on the request and response paths.
module tb_match_req_arbiter;
  import match_req_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int DEPTH = 16;

  logic                           clk;
  logic                           rst_n;
  logic [NR-1:0]                  up_req_valid;
  logic [NR-1:0]                  up_req_ready;
  logic [NR*ADDR_WIDTH-1:0]       up_req_head_addr;
  logic [NR*ADDR_WIDTH-1:0]       up_req_history_addr;
  logic [NR*MATCH_TAG_WIDTH-1:0]  up_req_tag;
  logic                           dn_req_valid;
  logic                           dn_req_ready;
  logic [ADDR_WIDTH-1:0]          dn_req_head_addr;
  logic [ADDR_WIDTH-1:0]          dn_req_history_addr;
  logic [MATCH_TAG_WIDTH-1:0]     dn_req_tag;
  logic                           dn_resp_valid;
  logic                           dn_resp_ready;
  logic [MATCH_LEN_WIDTH-1:0]     dn_resp_len;
  logic [MATCH_TAG_WIDTH-1:0]     dn_resp_tag;
  logic [NR-1:0]                  up_resp_valid;
  logic [NR-1:0]                  up_resp_ready;
  logic [NR*MATCH_LEN_WIDTH-1:0]  up_resp_len;
  logic [NR*MATCH_TAG_WIDTH-1:0]  up_resp_tag;
  logic [4:0]                     outstanding_cnt;
  logic                           stray_resp_err;

  int n_vec = 0;
  int n_err = 0;

  match_req_arbiter #(.NUM_REQ(NR), .OUTSTANDING_DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .up_req_valid_i        (up_req_valid),
    .up_req_ready_o        (up_req_ready),
    .up_req_head_addr_i    (up_req_head_addr),
    .up_req_history_addr_i (up_req_history_addr),
    .up_req_tag_i          (up_req_tag),
    .dn_req_valid_o        (dn_req_valid),
    .dn_req_ready_i        (dn_req_ready),
    .dn_req_head_addr_o    (dn_req_head_addr),
    .dn_req_history_addr_o (dn_req_history_addr),
    .dn_req_tag_o          (dn_req_tag),
    .dn_resp_valid_i       (dn_resp_valid),
    .dn_resp_ready_o       (dn_resp_ready),
    .dn_resp_len_i         (dn_resp_len),
    .dn_resp_tag_i         (dn_resp_tag),
    .up_resp_valid_o       (up_resp_valid),
    .up_resp_ready_i       (up_resp_ready),
    .up_resp_len_o         (up_resp_len),
    .up_resp_tag_o         (up_resp_tag),
    .outstanding_cnt_o     (outstanding_cnt),
    .stray_resp_err_o      (stray_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [ADDR_WIDTH-1:0]      head;
    logic [ADDR_WIDTH-1:0]      hist;
    logic [MATCH_TAG_WIDTH-1:0] tag;
  } exp_t;

  exp_t                       exp_q[$];
  bit                         m_valid [DEPTH];
  int                         m_owner [DEPTH];
  logic [MATCH_TAG_WIDTH-1:0] m_tag   [DEPTH];

  exp_t        mon_e;
  int          mon_fidx;
  int          mon_own;
  int          mon_rtag;
  bit          mon_rel;
  logic [NR-1:0] mon_gnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) m_valid[e] = 1'b0;
      exp_q.delete();
    end else begin
      mon_rel = 1'b0;
      if (dn_req_valid && dn_req_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_dn_req unexpected request: got tag %0d, none expected", dn_req_tag);
        end else begin
          mon_e = exp_q.pop_front();
          if ({dn_req_head_addr, dn_req_history_addr, dn_req_tag} !== {mon_e.head, mon_e.hist, mon_e.tag}) begin
            n_err++;
            $display("FAIL sb_dn_req got head=%h hist=%h tag=%0d expected head=%h hist=%h tag=%0d",
                     dn_req_head_addr, dn_req_history_addr, dn_req_tag, mon_e.head, mon_e.hist, mon_e.tag);
          end
        end
      end
      if (dn_resp_valid && dn_resp_ready) begin
        n_vec++;
        if ((dn_resp_tag < 8'(DEPTH)) && m_valid[dn_resp_tag[3:0]]) begin
          mon_rtag = int'(dn_resp_tag[3:0]);
          mon_own  = m_owner[mon_rtag];
          mon_rel  = 1'b1;
          if (up_resp_valid !== NR'(1 << mon_own) ||
              up_resp_tag[mon_own*MATCH_TAG_WIDTH +: MATCH_TAG_WIDTH] !== m_tag[mon_rtag] ||
              up_resp_len[mon_own*MATCH_LEN_WIDTH +: MATCH_LEN_WIDTH] !== dn_resp_len) begin
            n_err++;
            $display("FAIL sb_resp tag %0d got valid=%b utag=%h expected valid=%b utag=%h len=%0d",
                     dn_resp_tag, up_resp_valid, up_resp_tag[mon_own*MATCH_TAG_WIDTH +: MATCH_TAG_WIDTH],
                     NR'(1 << mon_own), m_tag[mon_rtag], dn_resp_len);
          end
        end else if (up_resp_valid !== '0) begin
          n_err++;
          $display("FAIL sb_stray tag %0d got up_resp_valid=%b expected 0", dn_resp_tag, up_resp_valid);
        end
      end
      mon_gnt = up_req_valid & up_req_ready;
      if (mon_gnt != '0) begin
        mon_fidx = -1;
        for (int e = DEPTH - 1; e >= 0; e--) if (!m_valid[e]) mon_fidx = e;
        mon_own = 0;
        for (int i = 0; i < NR; i++) if (mon_gnt[i]) mon_own = i;
        if (mon_fidx < 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_grant granted %b with full table, expected no grant", mon_gnt);
        end else begin
          mon_e.head = up_req_head_addr[mon_own*ADDR_WIDTH +: ADDR_WIDTH];
          mon_e.hist = up_req_history_addr[mon_own*ADDR_WIDTH +: ADDR_WIDTH];
          mon_e.tag  = 8'(mon_fidx);
          exp_q.push_back(mon_e);
          m_valid[mon_fidx] = 1'b1;
          m_owner[mon_fidx] = mon_own;
          m_tag[mon_fidx]   = up_req_tag[mon_own*MATCH_TAG_WIDTH +: MATCH_TAG_WIDTH];
        end
      end
      if (mon_rel) m_valid[mon_rtag] = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] tag, input logic [31:0] head, input logic [31:0] hist);
    up_req_tag[i*MATCH_TAG_WIDTH +: MATCH_TAG_WIDTH] = tag;
    up_req_head_addr[i*ADDR_WIDTH +: ADDR_WIDTH]     = head;
    up_req_history_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = hist;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    up_req_valid  = '0;
    dn_req_ready  = 1'b0;
    dn_resp_valid = 1'b0;
    up_resp_ready = '1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    up_req_valid = '1;
    dn_req_ready = 1'b1;
    tick();
    tick();
    #1;
    n_vec++;
    if (up_req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_up_req_ready got %b expected 0000", up_req_ready); end
    n_vec++;
    if (dn_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_dn_req_valid got %b expected 0", dn_req_valid); end
    n_vec++;
    if (outstanding_cnt !== 5'd0) begin n_err++; $display("FAIL reset_cnt got %0d expected 0", outstanding_cnt); end
    n_vec++;
    if (stray_resp_err !== 1'b0) begin n_err++; $display("FAIL reset_stray got %b expected 0", stray_resp_err); end
    up_req_valid = '0;
    dn_req_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    set_lane(1, 8'h5A, 32'h0000_0200, 32'h0000_0100);
    up_req_valid = 4'b0010;
    #1;
    n_vec++;
    if (up_req_ready !== 4'b0010) begin n_err++; $display("FAIL single_grant got %b expected 0010", up_req_ready); end
    tick();
    up_req_valid = '0;
    n_vec++;
    if ({dn_req_valid, dn_req_tag, dn_req_history_addr} !== {1'b1, 8'h00, 32'h0000_0100}) begin
      n_err++;
      $display("FAIL single_dn_req got valid=%b tag=%0d hist=%h expected 1 0 00000100", dn_req_valid, dn_req_tag, dn_req_history_addr);
    end
    dn_req_ready = 1'b1;
    tick();
    dn_req_ready = 1'b0;
    dn_resp_valid = 1'b1;
    dn_resp_tag   = 8'd0;
    dn_resp_len   = 16'd12;
    up_resp_ready = '1;
    #1;
    n_vec++;
    if ({up_resp_valid, up_resp_len[16 +: 16], up_resp_tag[8 +: 8], dn_resp_ready} !== {4'b0010, 16'd12, 8'h5A, 1'b1}) begin
      n_err++;
      $display("FAIL single_resp got valid=%b len=%0d tag=%h rdy=%b expected 0010 12 5a 1",
               up_resp_valid, up_resp_len[16 +: 16], up_resp_tag[8 +: 8], dn_resp_ready);
    end
    tick();
    dn_resp_valid = 1'b0;
    n_vec++;
    if (outstanding_cnt !== 5'd0) begin n_err++; $display("FAIL single_cnt got %0d expected 0", outstanding_cnt); end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < NR; i++) set_lane(i, 8'(8'hA0 + i), 32'h1000 + i, 32'h2000 + i);
    up_req_valid = 4'hF;
    dn_req_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      n_vec++;
      if (up_req_ready !== NR'(1 << (k % NR))) begin
        n_err++;
        $display("FAIL fair_grant_%0d got %b expected %b", k, up_req_ready, NR'(1 << (k % NR)));
      end
      tick();
    end
    #1;
    n_vec++;
    if ({up_req_ready, outstanding_cnt} !== {4'b0000, 5'd16}) begin
      n_err++;
      $display("FAIL fair_full got ready=%b cnt=%0d expected 0000 16", up_req_ready, outstanding_cnt);
    end
    tick();
    n_vec++;
    if ({up_req_ready, outstanding_cnt} !== {4'b0000, 5'd16}) begin
      n_err++;
      $display("FAIL fair_full_hold got ready=%b cnt=%0d expected 0000 16", up_req_ready, outstanding_cnt);
    end
  endtask

  task automatic test_full_swap();
    up_req_valid  = 4'b0100;
    dn_resp_valid = 1'b1;
    dn_resp_tag   = 8'd7;
    dn_resp_len   = 16'd33;
    up_resp_ready = '1;
    #1;
    n_vec++;
    if ({up_req_ready, up_resp_valid, dn_resp_ready} !== {4'b0000, 4'b1000, 1'b1}) begin
      n_err++;
      $display("FAIL swap_free_cycle got ready=%b resp_valid=%b rdy=%b expected 0000 1000 1", up_req_ready, up_resp_valid, dn_resp_ready);
    end
    tick();
    dn_resp_tag = 8'd0;
    #1;
    n_vec++;
    if ({up_req_ready, outstanding_cnt} !== {4'b0100, 5'd15}) begin
      n_err++;
      $display("FAIL swap_grant got ready=%b cnt=%0d expected 0100 15", up_req_ready, outstanding_cnt);
    end
    tick();
    dn_resp_valid = 1'b0;
    n_vec++;
    if ({dn_req_valid, dn_req_tag, outstanding_cnt} !== {1'b1, 8'd7, 5'd15}) begin
      n_err++;
      $display("FAIL swap_reuse got valid=%b tag=%0d cnt=%0d expected 1 7 15", dn_req_valid, dn_req_tag, outstanding_cnt);
    end
    #1;
    n_vec++;
    if (up_req_ready !== 4'b0100) begin n_err++; $display("FAIL swap_regrant got %b expected 0100", up_req_ready); end
    tick();
    up_req_valid = '0;
    n_vec++;
    if ({dn_req_tag, outstanding_cnt} !== {8'd0, 5'd16}) begin
      n_err++;
      $display("FAIL swap_refill got tag=%0d cnt=%0d expected 0 16", dn_req_tag, outstanding_cnt);
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < NR; i++) set_lane(i, 8'(8'hB0 + i), 32'h3000 + i, 32'h4000 + i);
    up_req_valid = 4'b0011;
    dn_req_ready = 1'b0;
    #1;
    n_vec++;
    if (up_req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_first got %b expected 0001", up_req_ready); end
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++;
      if ({up_req_ready, dn_req_valid, dn_req_head_addr, dn_req_tag, outstanding_cnt} !==
          {4'b0000, 1'b1, 32'h3000, 8'd0, 5'd1}) begin
        n_err++;
        $display("FAIL bp_stall_%0d got ready=%b valid=%b head=%h tag=%0d cnt=%0d expected 0000 1 3000 0 1",
                 c, up_req_ready, dn_req_valid, dn_req_head_addr, dn_req_tag, outstanding_cnt);
      end
      tick();
    end
    dn_req_ready = 1'b1;
    #1;
    n_vec++;
    if (up_req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_drain_grant got %b expected 0010", up_req_ready); end
    tick();
    up_req_valid = '0;
    n_vec++;
    if ({dn_req_valid, dn_req_head_addr, dn_req_tag, outstanding_cnt} !== {1'b1, 32'h3001, 8'd1, 5'd2}) begin
      n_err++;
      $display("FAIL bp_after got valid=%b head=%h tag=%0d cnt=%0d expected 1 3001 1 2",
               dn_req_valid, dn_req_head_addr, dn_req_tag, outstanding_cnt);
    end
    tick();
  endtask

  task automatic test_out_of_order();
    int order [3];
    int t;
    order = '{3, 1, 2};
    do_reset();
    for (int i = 0; i < NR; i++) set_lane(i, 8'(8'hC0 + i), 32'h5000 + i, 32'h6000 + i);
    up_req_valid = 4'hF;
    dn_req_ready = 1'b1;
    for (int k = 0; k < NR; k++) tick();
    up_req_valid = '0;
    tick();
    for (int j = 0; j < 3; j++) begin
      t = order[j];
      dn_resp_valid = 1'b1;
      dn_resp_tag   = 8'(t);
      dn_resp_len   = 16'(40 + t);
      up_resp_ready = '0;
      for (int c = 0; c < 2; c++) begin
        #1;
        n_vec++;
        if ({dn_resp_ready, up_resp_valid} !== {1'b0, NR'(1 << t)}) begin
          n_err++;
          $display("FAIL ooo_stall_tag%0d got rdy=%b valid=%b expected 0 %b", t, dn_resp_ready, up_resp_valid, NR'(1 << t));
        end
        tick();
      end
      up_resp_ready = NR'(1 << t);
      #1;
      n_vec++;
      if ({dn_resp_ready, up_resp_tag[t*8 +: 8]} !== {1'b1, 8'(8'hC0 + t)}) begin
        n_err++;
        $display("FAIL ooo_deliver_tag%0d got rdy=%b tag=%h expected 1 %h", t, dn_resp_ready, up_resp_tag[t*8 +: 8], 8'(8'hC0 + t));
      end
      tick();
      dn_resp_valid = 1'b0;
      up_resp_ready = '1;
    end
    n_vec++;
    if (outstanding_cnt !== 5'd1) begin n_err++; $display("FAIL ooo_cnt got %0d expected 1", outstanding_cnt); end
  endtask

  task automatic test_stray();
    dn_resp_valid = 1'b1;
    dn_resp_tag   = 8'd9;
    dn_resp_len   = 16'd5;
    up_resp_ready = '0;
    #1;
    n_vec++;
    if ({dn_resp_ready, up_resp_valid} !== {1'b1, 4'b0000}) begin
      n_err++;
      $display("FAIL stray9 got rdy=%b valid=%b expected 1 0000", dn_resp_ready, up_resp_valid);
    end
    tick();
    n_vec++;
    if (stray_resp_err !== 1'b1) begin n_err++; $display("FAIL stray_set got %b expected 1", stray_resp_err); end
    dn_resp_tag = 8'd200;
    #1;
    n_vec++;
    if ({dn_resp_ready, up_resp_valid} !== {1'b1, 4'b0000}) begin
      n_err++;
      $display("FAIL stray_range got rdy=%b valid=%b expected 1 0000", dn_resp_ready, up_resp_valid);
    end
    tick();
    dn_resp_valid = 1'b0;
    up_resp_ready = '1;
    tick();
    tick();
    n_vec++;
    if ({stray_resp_err, outstanding_cnt} !== {1'b1, 5'd1}) begin
      n_err++;
      $display("FAIL stray_sticky got err=%b cnt=%0d expected 1 1", stray_resp_err, outstanding_cnt);
    end
    rst_n = 1'b0;
    tick();
    n_vec++;
    if (stray_resp_err !== 1'b0) begin n_err++; $display("FAIL stray_clear got %b expected 0", stray_resp_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midop();
    set_lane(0, 8'h11, 32'h7000, 32'h8000);
    up_req_valid = 4'b0001;
    dn_req_ready = 1'b1;
    tick();
    up_req_valid = '0;
    n_vec++;
    if (outstanding_cnt !== 5'd1) begin n_err++; $display("FAIL midop_alloc got %0d expected 1", outstanding_cnt); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    dn_resp_valid = 1'b1;
    dn_resp_tag   = 8'd0;
    dn_resp_len   = 16'd7;
    #1;
    n_vec++;
    if ({dn_resp_ready, up_resp_valid} !== {1'b1, 4'b0000}) begin
      n_err++;
      $display("FAIL midop_resp got rdy=%b valid=%b expected 1 0000", dn_resp_ready, up_resp_valid);
    end
    tick();
    dn_resp_valid = 1'b0;
    n_vec++;
    if ({stray_resp_err, outstanding_cnt} !== {1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL midop_stray got err=%b cnt=%0d expected 1 0", stray_resp_err, outstanding_cnt);
    end
  endtask

  initial begin
    rst_n               = 1'b0;
    up_req_valid        = '0;
    up_req_head_addr    = '0;
    up_req_history_addr = '0;
    up_req_tag          = '0;
    dn_req_ready        = 1'b0;
    dn_resp_valid       = 1'b0;
    dn_resp_len         = '0;
    dn_resp_tag         = '0;
    up_resp_ready       = '1;
    test_reset();
    test_single();
    test_fairness();
    test_full_swap();
    test_backpressure();
    test_out_of_order();
    test_stray();
    test_reset_midop();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
